// File: rtl/ripple_seq_adder.sv
// Sequential WIDTH-bit adder that time-shares one 4-bit ripple slice, LSB nibble first.
// Optional subtract mode is enabled by defining RIPPLE_SEQ_SUB_EN (adds the `sub` port).

module ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module ripple_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef RIPPLE_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sh_a, sh_b;
  logic [WIDTH-5:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  ripple_adder u_slice (
    .a    (sh_a[3:0]),
    .b    (sh_b[3:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // The accumulator keeps only the upper WIDTH-4 bits; the newest nibble
  // enters at the MSB and the full word is formed on the last pass.
  assign acc_next = {slice_sum, acc};

`ifdef RIPPLE_SEQ_SUB_EN
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = op_b;
  assign c_load = cin;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= op_a;
            sh_b  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= {4'b0000, sh_a[WIDTH-1:4]};
          sh_b  <= {4'b0000, sh_b[WIDTH-1:4]};
          acc   <= acc_next[WIDTH-1:4];
          carry <= slice_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= acc_next;
            cout   <= slice_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ripple_seq_adder.sv
// Self-checking bench for ripple_seq_adder: arithmetic/timing model plus directed vectors.
`timescale 1ns/1ps

module tb_ripple_seq_adder;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;

  int tests = 0;
  int fails = 0;

  ripple_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
`ifdef RIPPLE_SEQ_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  // Model: an accepted op occupies edges 0..NIBBLES+1 after acceptance;
  // outputs update NIBBLES edges after acceptance.
  logic             m_active = 1'b0;
  int               m_k = 0;
  logic [WIDTH:0]   m_pend = '0;
  logic             m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0;
  logic [WIDTH-1:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_k = 0;
      m_res = '0; m_cout = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_k = 0;
`ifdef RIPPLE_SEQ_SUB_EN
        if (sub) m_pend = {1'b0, op_a} + {1'b0, ~op_b} + 1;
        else     m_pend = {1'b0, op_a} + {1'b0, op_b} + cin;
`else
        m_pend = {1'b0, op_a} + {1'b0, op_b} + cin;
`endif
      end
    end else begin
      m_k = m_k + 1;
      if (m_k == NIBBLES) begin
        m_res  = m_pend[WIDTH-1:0];
        m_cout = m_pend[WIDTH];
      end else if (m_k == NIBBLES + 1) begin
        m_active = 1'b0;
      end
    end
    m_busy = m_active;
    m_done = m_active && (m_k == NIBBLES);
  end

  always @(posedge clk) begin
    #1;
    tests++;
    if (busy !== m_busy || done !== m_done || result !== m_res || cout !== m_cout) begin
      fails++;
      $display("FAIL model t=%0t busy=%b/%b done=%b/%b result=%h/%h cout=%b/%b (actual/required)",
               $time, busy, m_busy, done, m_done, result, m_res, cout, m_cout);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issues one op, waits (bounded) for done, checks result/cout, latency and busy length.
  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic s, input logic [WIDTH-1:0] er, input logic ec);
    int lat;
    int bcnt;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      op_a = ~a; op_b = ~b; cin = ~c;
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
    end
    check({name, "_lat"}, lat, NIBBLES + 1);
    check({name, "_res"}, result, er);
    check({name, "_cout"}, cout, ec);
    @(negedge clk);
    if (busy) bcnt++;
    @(negedge clk);
    check({name, "_busylen"}, bcnt, NIBBLES + 1);
    check({name, "_idle"}, busy, 0);
  endtask

  int d1, d2;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("a1p2", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);
    run_op("ffffp1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("ffffpffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    run_op("mixed", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0);

    // start held high through RUN/DONE: only re-accepted after returning to IDLE
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      op_a = 16'hAAAA;
      if (done && d1 == 0) begin
        d1 = i;
        check("hold_first", result, 16'h2345);
      end else if (done) begin
        d2 = i;
        check("hold_second", result, 16'hBBBB);
        break;
      end
    end
    start = 1'b0;
    check("hold_first_at", d1, NIBBLES + 1);
    check("hold_gap", d2 - d1, NIBBLES + 2);
    repeat (3) @(negedge clk);

    // reset asserted just after edge 2 of an operation
    op_a = 16'h00FF; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d1 = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) d1++;
    end
    check("abort_nodone", d1, 0);
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

`ifdef RIPPLE_SEQ_SUB_EN
    run_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub7m5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("sub0add", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached t=%0t required=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
